// File: rtl/result_piso_tx_pkg.sv
// Shared types and constants for the 2x2 result serial transmitter.
package result_piso_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_DONE  = 2'd2
  } tx_state_t;

  localparam int unsigned N_WORDS    = 4;
  localparam int unsigned DEF_WORD_W = 4;
  localparam int unsigned FRAME_BITS = N_WORDS * DEF_WORD_W;

endpackage

// File: rtl/result_piso_tx_shift.sv
// Single-word parallel-in/serial-out shift register.
// The outgoing bit is taken straight from a flop, so o_bit is registered.
module piso_shift_register #(
  parameter int unsigned WORD_W    = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_d,
  output logic              o_bit
);

  logic [WORD_W-1:0] r_sr;

  // Load has priority over shift; vacated positions fill with zero.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_d;
    end else if (i_shift) begin
      if (MSB_FIRST) r_sr <= {r_sr[WORD_W-2:0], 1'b0};
      else           r_sr <= {1'b0, r_sr[WORD_W-1:1]};
    end
  end

  assign o_bit = MSB_FIRST ? r_sr[WORD_W-1] : r_sr[0];

endmodule

// File: rtl/result_piso_tx.sv
// Framed serial transmitter for the C00..C11 result words.
// A rising edge on send snapshots the four words and shifts them out
// word by word (C00 first) at the bit_en rate, then pulses done.
module result_piso_tx
  import result_piso_tx_pkg::*;
#(
  parameter int unsigned WORD_W    = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              send,
  input  logic              bit_en,
  input  logic [WORD_W-1:0] C00,
  input  logic [WORD_W-1:0] C01,
  input  logic [WORD_W-1:0] C10,
  input  logic [WORD_W-1:0] C11,
  output logic              sdo,
  output logic              frame,
  output logic              word_end,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WORD_W - 1);
  localparam logic [1:0]       LAST_WORD = 2'(N_WORDS - 1);

  tx_state_t         r_state;
  logic              r_send_q;
  logic [WORD_W-1:0] r_shadow [N_WORDS];
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [1:0]        r_word_idx;
  logic              r_frame;
  logic              r_word_end;
  logic              r_done;

  logic              w_trig;
  logic              w_last_bit;
  logic              w_last_word;
  logic [CNT_W-1:0]  w_next_cnt;
  logic [1:0]        w_next_idx;
  logic              w_sr_load;
  logic              w_sr_shift;
  logic [WORD_W-1:0] w_sr_d;
  logic              w_sr_bit;

  assign w_trig      = send & ~r_send_q;
  assign w_last_bit  = (r_bit_cnt == LAST_BIT);
  assign w_last_word = (r_word_idx == LAST_WORD);
  assign w_next_cnt  = r_bit_cnt + CNT_W'(1);
  assign w_next_idx  = r_word_idx + 2'd1;

  // Shift-register control: the first word loads straight from C00 on the
  // launch edge; later words reload from the snapshot; zeros clear sdo at end.
  always_comb begin
    w_sr_load  = 1'b0;
    w_sr_shift = 1'b0;
    w_sr_d     = '0;
    case (r_state)
      TX_IDLE: begin
        if (w_trig) begin
          w_sr_load = 1'b1;
          w_sr_d    = C00;
        end
      end
      TX_SHIFT: begin
        if (bit_en) begin
          if (w_last_bit) begin
            w_sr_load = 1'b1;
            w_sr_d    = w_last_word ? '0 : r_shadow[w_next_idx];
          end else begin
            w_sr_shift = 1'b1;
          end
        end
      end
      default: begin
        w_sr_load = 1'b1;
        w_sr_d    = '0;
      end
    endcase
  end

  piso_shift_register #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .nRST    (nRST),
    .i_load  (w_sr_load),
    .i_shift (w_sr_shift),
    .i_d     (w_sr_d),
    .o_bit   (w_sr_bit)
  );

  // Edge detect, snapshot, bit/word counters and framing FSM.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state    <= TX_IDLE;
      r_send_q   <= 1'b0;
      r_bit_cnt  <= '0;
      r_word_idx <= '0;
      r_frame    <= 1'b0;
      r_word_end <= 1'b0;
      r_done     <= 1'b0;
      for (int unsigned i = 0; i < N_WORDS; i++) r_shadow[i] <= '0;
    end else begin
      r_send_q <= send;
      case (r_state)
        TX_IDLE: begin
          r_done <= 1'b0;
          if (w_trig) begin
            r_shadow[0] <= C00;
            r_shadow[1] <= C01;
            r_shadow[2] <= C10;
            r_shadow[3] <= C11;
            r_state     <= TX_SHIFT;
            r_bit_cnt   <= '0;
            r_word_idx  <= '0;
            r_frame     <= 1'b1;
            r_word_end  <= (LAST_BIT == '0);
          end
        end
        TX_SHIFT: begin
          if (bit_en) begin
            if (w_last_bit) begin
              r_bit_cnt <= '0;
              if (w_last_word) begin
                r_state    <= TX_DONE;
                r_word_idx <= '0;
                r_frame    <= 1'b0;
                r_word_end <= 1'b0;
                r_done     <= 1'b1;
              end else begin
                r_word_idx <= w_next_idx;
                r_word_end <= (LAST_BIT == '0);
              end
            end else begin
              r_bit_cnt  <= w_next_cnt;
              r_word_end <= (w_next_cnt == LAST_BIT);
            end
          end
        end
        TX_DONE: begin
          r_done  <= 1'b0;
          r_state <= TX_IDLE;
        end
        default: begin
          r_state    <= TX_IDLE;
          r_frame    <= 1'b0;
          r_word_end <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign sdo      = w_sr_bit;
  assign frame    = r_frame;
  assign word_end = r_word_end;
  assign done     = r_done;
  assign busy     = (r_state != TX_IDLE);

endmodule

// File: tb/tb_result_piso_tx.sv
// Directed bench for result_piso_tx: one MSB-first and one LSB-first
// instance share all stimulus.
module tb_result_piso_tx;

  logic       clk = 1'b0;
  logic       nRST;
  logic       send;
  logic       bit_en;
  logic [3:0] C00, C01, C10, C11;
  logic       sdo_m, frame_m, word_end_m, busy_m, done_m;
  logic       sdo_l, frame_l, word_end_l, busy_l, done_l;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] stream_m;
  logic [15:0] stream_l;
  logic [15:0] stream_f;
  logic [15:0] got;

  always #5 clk = ~clk;

  result_piso_tx #(.WORD_W(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .nRST(nRST), .send(send), .bit_en(bit_en),
    .C00(C00), .C01(C01), .C10(C10), .C11(C11),
    .sdo(sdo_m), .frame(frame_m), .word_end(word_end_m),
    .busy(busy_m), .done(done_m)
  );

  result_piso_tx #(.WORD_W(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .nRST(nRST), .send(send), .bit_en(bit_en),
    .C00(C00), .C01(C01), .C10(C10), .C11(C11),
    .sdo(sdo_l), .frame(frame_l), .word_end(word_end_l),
    .busy(busy_l), .done(done_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; send = 1'b0; bit_en = 1'b1;
    C00 = 4'hA; C01 = 4'h3; C10 = 4'h5; C11 = 4'hC;
    #3;
    n_checks++;
    if ({sdo_m, frame_m, word_end_m, busy_m, done_m} !== 5'b0)
      $display("FAIL reset_outs_m: got %b expected 00000", {sdo_m, frame_m, word_end_m, busy_m, done_m});
    else n_pass++;
    n_checks++;
    if ({sdo_l, frame_l, word_end_l, busy_l, done_l} !== 5'b0)
      $display("FAIL reset_outs_l: got %b expected 00000", {sdo_l, frame_l, word_end_l, busy_l, done_l});
    else n_pass++;
    tick(); tick();
    nRST = 1'b1;
    tick(); tick();
    n_checks++;
    if ({busy_m, frame_m, done_m} !== 3'b0)
      $display("FAIL post_reset_idle: got %b expected 000", {busy_m, frame_m, done_m});
    else n_pass++;
  endtask

  task automatic test_basic();
    bit_en = 1'b1;
    send   = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_checks++;
      if (sdo_m !== stream_m[15-k]) $display("FAIL basic_sdo_m[%0d]: got %b expected %b", k, sdo_m, stream_m[15-k]);
      else n_pass++;
      n_checks++;
      if (sdo_l !== stream_l[15-k]) $display("FAIL basic_sdo_l[%0d]: got %b expected %b", k, sdo_l, stream_l[15-k]);
      else n_pass++;
      n_checks++;
      if ({frame_m, busy_m, done_m} !== 3'b110)
        $display("FAIL basic_frame[%0d]: got %b expected 110", k, {frame_m, busy_m, done_m});
      else n_pass++;
      n_checks++;
      if (word_end_m !== ((k % 4) == 3)) $display("FAIL basic_word_end[%0d]: got %b expected %b", k, word_end_m, (k % 4) == 3);
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({sdo_m, frame_m, word_end_m, done_m, busy_m} !== 5'b00011)
      $display("FAIL basic_done: got %b expected 00011", {sdo_m, frame_m, word_end_m, done_m, busy_m});
    else n_pass++;
    tick();
    n_checks++;
    if ({done_m, busy_m, done_l, busy_l} !== 4'b0)
      $display("FAIL basic_idle: got %b expected 0000", {done_m, busy_m, done_l, busy_l});
    else n_pass++;
    send = 1'b0;
    tick();
  endtask

  task automatic test_snapshot_retrigger();
    int frame_cnt;
    int done_cnt;
    send = 1'b1;
    tick();
    got[15] = sdo_m;
    C00 = 4'hF;
    for (int k = 1; k < 16; k++) begin
      tick();
      got[15-k] = sdo_m;
    end
    n_checks++;
    if (got !== stream_m) $display("FAIL snapshot_stream: got %h expected %h", got, stream_m);
    else n_pass++;
    frame_cnt = 0;
    done_cnt  = 0;
    for (int k = 16; k < 30; k++) begin
      tick();
      frame_cnt += int'(frame_m);
      done_cnt  += int'(done_m);
    end
    n_checks++;
    if (frame_cnt !== 0) $display("FAIL held_send_retrigger: got %0d frame cycles expected 0", frame_cnt);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL held_send_done: got %0d done cycles expected 1", done_cnt);
    else n_pass++;
    send = 1'b0;
    tick();
    send = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      got[15-k] = sdo_m;
    end
    n_checks++;
    if (got !== stream_f) $display("FAIL retrigger_stream: got %h expected %h", got, stream_f);
    else n_pass++;
    tick(); tick();
    send = 1'b0;
    C00  = 4'hA;
    tick();
  endtask

  task automatic test_throttle();
    int idx;
    int frame_cnt;
    frame_cnt = 0;
    bit_en = 1'b0;
    send   = 1'b1;
    tick();
    frame_cnt += int'(frame_m);
    n_checks++;
    if (sdo_m !== stream_m[15]) $display("FAIL throttle_first_bit: got %b expected %b", sdo_m, stream_m[15]);
    else n_pass++;
    for (int j = 1; j <= 50; j++) begin
      bit_en = ((j % 3) == 1);
      tick();
      frame_cnt += int'(frame_m);
      if (j <= 45) begin
        idx = (j + 2) / 3;
        n_checks++;
        if (sdo_m !== stream_m[15-idx] || frame_m !== 1'b1 || done_m !== 1'b0)
          $display("FAIL throttle_bit[%0d]: got sdo=%b frame=%b done=%b expected sdo=%b frame=1 done=0",
                   j, sdo_m, frame_m, done_m, stream_m[15-idx]);
        else n_pass++;
      end else if (j == 46) begin
        n_checks++;
        if ({frame_m, done_m, busy_m} !== 3'b011)
          $display("FAIL throttle_done: got %b expected 011", {frame_m, done_m, busy_m});
        else n_pass++;
      end else if (j == 47) begin
        n_checks++;
        if ({done_m, busy_m} !== 2'b00)
          $display("FAIL throttle_done_width: got %b expected 00", {done_m, busy_m});
        else n_pass++;
      end
    end
    n_checks++;
    if (frame_cnt !== 46) $display("FAIL throttle_frame_len: got %0d expected 46", frame_cnt);
    else n_pass++;
    bit_en = 1'b1;
    send   = 1'b0;
    tick();
  endtask

  task automatic test_ignored_trigger();
    int done_cnt;
    done_cnt = 0;
    bit_en = 1'b1;
    send   = 1'b1;
    tick();
    got[15] = sdo_m;
    for (int k = 1; k < 16; k++) begin
      if (k == 4) send = 1'b0;
      if (k == 5) send = 1'b1;
      tick();
      got[15-k] = sdo_m;
      done_cnt += int'(done_m);
    end
    n_checks++;
    if (got !== stream_m) $display("FAIL ignored_trig_stream: got %h expected %h", got, stream_m);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      tick();
      done_cnt += int'(done_m);
    end
    n_checks++;
    if (done_cnt !== 1) $display("FAIL ignored_trig_done: got %0d done cycles expected 1", done_cnt);
    else n_pass++;
    send = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    int done_cnt;
    bit_en = 1'b1;
    send   = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    n_checks++;
    if ({frame_m, busy_m} !== 2'b11) $display("FAIL midframe_active: got %b expected 11", {frame_m, busy_m});
    else n_pass++;
    #2 nRST = 1'b0;
    #1;
    n_checks++;
    if ({sdo_m, frame_m, word_end_m, busy_m, done_m} !== 5'b0)
      $display("FAIL midframe_reset_m: got %b expected 00000", {sdo_m, frame_m, word_end_m, busy_m, done_m});
    else n_pass++;
    n_checks++;
    if ({sdo_l, frame_l, word_end_l, busy_l, done_l} !== 5'b0)
      $display("FAIL midframe_reset_l: got %b expected 00000", {sdo_l, frame_l, word_end_l, busy_l, done_l});
    else n_pass++;
    send = 1'b0;
    tick(); tick();
    #2 nRST = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      done_cnt += int'(done_m);
      n_checks++;
      if ({busy_m, frame_m} !== 2'b00) $display("FAIL post_release_idle[%0d]: got %b expected 00", k, {busy_m, frame_m});
      else n_pass++;
    end
    n_checks++;
    if (done_cnt !== 0) $display("FAIL reset_no_done: got %0d expected 0", done_cnt);
    else n_pass++;
    send = 1'b1;
    tick();
    n_checks++;
    if ({busy_m, frame_m, sdo_m} !== 3'b111)
      $display("FAIL relaunch: got %b expected 111", {busy_m, frame_m, sdo_m});
    else n_pass++;
    for (int k = 0; k < 17; k++) tick();
    n_checks++;
    if (busy_m !== 1'b0) $display("FAIL relaunch_end: got %b expected 0", busy_m);
    else n_pass++;
    send = 1'b0;
    tick();
  endtask

  initial begin
    stream_m = 16'hA35C;
    stream_l = 16'h5CA3;
    stream_f = 16'hF35C;
    test_reset();
    test_basic();
    test_snapshot_retrigger();
    test_throttle();
    test_ignored_trigger();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
